camera_stream_tx: RTL and testbench

//  Camera-side transmitter for the 8-bit VSYNC/HREF parallel pixel bus: serialises 16-bit

---
 rtl/camera_stream_tx.sv | 242 ++++++++++++++++++++++++
 tb/tb_camera_stream_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/camera_stream_tx.sv
// camera_stream_tx
// Stand-in camera sensor for the 8-bit VSYNC/HREF parallel pixel bus.
// The block pulls 16-bit pixels from an upstream valid/ready source and
// sends each one as two bytes, high byte first. Frame blanking and line
// blanking are set by parameters. Timing never stalls: if the source is
// not valid when a pixel is requested, zero is sent and underrun_out
// pulses on the next cycle.
module camera_stream_tx #(
  parameter int WIDTH         = 320,
  parameter int HEIGHT        = 240,
  parameter int VSYNC_CYCLES  = 1568,
  parameter int VBACK_CYCLES  = 100,
  parameter int HBLANK_CYCLES = 144,
  parameter int VFRONT_CYCLES = 100
) (
  input  logic        pixel_clock_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [15:0] pixel_data_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  output logic [9:0]  frame_x_out,
  output logic [8:0]  frame_y_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  byte_out,
  output logic        frame_start_out,
  output logic        underrun_out
);

  // Terminal values for the counters, computed at the counter widths.
  localparam logic [15:0] VS_LAST = 16'(VSYNC_CYCLES - 1);
  localparam logic [15:0] VB_LAST = 16'(VBACK_CYCLES - 1);
  localparam logic [15:0] HB_LAST = 16'(HBLANK_CYCLES - 1);
  localparam logic [15:0] VF_LAST = 16'(VFRONT_CYCLES - 1);
  localparam logic [9:0]  X_LAST  = 10'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST  = 9'(HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_LINE   = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFRONT = 3'd5
  } state_t;

  state_t      state_r;
  logic [15:0] cnt_r;       // cycles spent in the current blanking/sync state
  logic [9:0]  x_r;         // pixel currently on the pins
  logic [8:0]  y_r;         // line currently on the pins
  logic        phase_r;     // 0 = high-byte cycle, 1 = low-byte cycle
  logic [7:0]  low_byte_r;  // low byte of the pixel being sent
  logic        vsync_r;
  logic        href_r;
  logic        frame_start_r;
  logic [7:0]  byte_r;
  logic        underrun_r;

  logic        ready_s;
  logic [9:0]  req_x_s;
  logic [8:0]  req_y_s;

  assign pixel_ready_out = ready_s;
  assign frame_x_out     = req_x_s;
  assign frame_y_out     = req_y_s;
  assign vsync_out       = vsync_r;
  assign href_out        = href_r;
  assign byte_out        = byte_r;
  assign frame_start_out = frame_start_r;
  assign underrun_out    = underrun_r;

  // Request a pixel one cycle before its high byte appears on the pins and report its coordinates.
  always_comb begin
    ready_s = 1'b0;
    req_x_s = 10'd0;
    req_y_s = y_r;
    case (state_r)
      ST_VBACK: begin
        req_x_s = 10'd0;
        req_y_s = 9'd0;
        if (cnt_r == VB_LAST) begin
          ready_s = 1'b1;
        end else begin
          ready_s = 1'b0;
        end
      end
      ST_LINE: begin
        req_x_s = x_r + 10'd1;
        req_y_s = y_r;
        if (phase_r && (x_r != X_LAST)) begin
          ready_s = 1'b1;
        end else begin
          ready_s = 1'b0;
        end
      end
      ST_HBLANK: begin
        req_x_s = 10'd0;
        req_y_s = y_r + 9'd1;
        if ((cnt_r == HB_LAST) && (y_r != Y_LAST)) begin
          ready_s = 1'b1;
        end else begin
          ready_s = 1'b0;
        end
      end
      default: begin
        ready_s = 1'b0;
        req_x_s = 10'd0;
        req_y_s = y_r;
      end
    endcase
  end

  // Frame timing state machine: sequences sync, blanking and line states and drives sync outputs.
  always_ff @(posedge pixel_clock_in) begin
    if (rst_in) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 16'd0;
      x_r           <= 10'd0;
      y_r           <= 9'd0;
      phase_r       <= 1'b0;
      vsync_r       <= 1'b0;
      href_r        <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enable_in) begin
            state_r       <= ST_VSYNC;
            cnt_r         <= 16'd0;
            vsync_r       <= 1'b1;
            frame_start_r <= 1'b1;
          end else begin
            cnt_r <= 16'd0;
          end
        end
        ST_VSYNC: begin
          if (cnt_r == VS_LAST) begin
            state_r <= ST_VBACK;
            cnt_r   <= 16'd0;
            vsync_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_VBACK: begin
          if (cnt_r == VB_LAST) begin
            state_r <= ST_LINE;
            cnt_r   <= 16'd0;
            x_r     <= 10'd0;
            y_r     <= 9'd0;
            phase_r <= 1'b0;
            href_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_LINE: begin
          if (!phase_r) begin
            phase_r <= 1'b1;
          end else if (x_r == X_LAST) begin
            // Last low byte of the line: drop href and enter line blanking.
            state_r <= ST_HBLANK;
            cnt_r   <= 16'd0;
            x_r     <= 10'd0;
            phase_r <= 1'b0;
            href_r  <= 1'b0;
          end else begin
            x_r     <= x_r + 10'd1;
            phase_r <= 1'b0;
          end
        end
        ST_HBLANK: begin
          if (cnt_r != HB_LAST) begin
            cnt_r <= cnt_r + 16'd1;
          end else if (y_r == Y_LAST) begin
            state_r <= ST_VFRONT;
            cnt_r   <= 16'd0;
            y_r     <= 9'd0;
          end else begin
            state_r <= ST_LINE;
            cnt_r   <= 16'd0;
            y_r     <= y_r + 9'd1;
            x_r     <= 10'd0;
            phase_r <= 1'b0;
            href_r  <= 1'b1;
          end
        end
        ST_VFRONT: begin
          if (cnt_r != VF_LAST) begin
            cnt_r <= cnt_r + 16'd1;
          end else if (enable_in) begin
            state_r       <= ST_VSYNC;
            cnt_r         <= 16'd0;
            vsync_r       <= 1'b1;
            frame_start_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 16'd0;
          x_r     <= 10'd0;
          y_r     <= 9'd0;
          phase_r <= 1'b0;
          vsync_r <= 1'b0;
          href_r  <= 1'b0;
        end
      endcase
    end
  end

  // Byte path: capture the requested pixel (or zero on underrun), then present high and low bytes.
  always_ff @(posedge pixel_clock_in) begin
    if (rst_in) begin
      byte_r     <= 8'd0;
      low_byte_r <= 8'd0;
      underrun_r <= 1'b0;
    end else if (ready_s) begin
      if (pixel_valid_in) begin
        byte_r     <= pixel_data_in[15:8];
        low_byte_r <= pixel_data_in[7:0];
        underrun_r <= 1'b0;
      end else begin
        byte_r     <= 8'd0;
        low_byte_r <= 8'd0;
        underrun_r <= 1'b1;
      end
    end else begin
      underrun_r <= 1'b0;
      if ((state_r == ST_LINE) && !phase_r) begin
        byte_r <= low_byte_r;
      end else begin
        byte_r <= byte_r;
      end
    end
  end

endmodule

// File: tb/tb_camera_stream_tx.sv
// Directed bench for camera_stream_tx with W=4, H=2, VS=3, VB=2, HB=2, VF=2.
// Frame position p runs 0..26: vsync p0-2, vback p3-4, line0 p5-12,
// hblank p13-14, line1 p15-22, hblank p23-24, vfront p25-26.
module tb_camera_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] pdata;
  logic        pvalid;
  logic        ready;
  logic [9:0]  fx;
  logic [8:0]  fy;
  logic        vsync;
  logic        href;
  logic [7:0]  bout;
  logic        fstart;
  logic        underrun;

  int n_assert = 0;
  int n_fail   = 0;
  int n_ready  = 0;

  // Expected values for the current frame position
  logic       e_vsync, e_fs, e_href, e_ready, e_under;
  logic [9:0] e_x;
  logic [8:0] e_y;
  logic [7:0] e_byte;

  camera_stream_tx #(
    .WIDTH(4), .HEIGHT(2), .VSYNC_CYCLES(3), .VBACK_CYCLES(2),
    .HBLANK_CYCLES(2), .VFRONT_CYCLES(2)
  ) dut (
    .pixel_clock_in (clk),
    .rst_in         (rst),
    .enable_in      (enable),
    .pixel_data_in  (pdata),
    .pixel_valid_in (pvalid),
    .pixel_ready_out(ready),
    .frame_x_out    (fx),
    .frame_y_out    (fy),
    .vsync_out      (vsync),
    .href_out       (href),
    .byte_out       (bout),
    .frame_start_out(fstart),
    .underrun_out   (underrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-derived expectations for frame position p; uf marks the frame with the x=2,y=1 underrun.
  task automatic model(input int p, input bit uf);
    int ln;
    int o;
    int px;
    logic [3:0] lnv;
    logic [3:0] pxv;
    ln = -1;
    o  = 0;
    if (p >= 5 && p <= 12) begin ln = 0; o = p - 5; end
    if (p >= 15 && p <= 22) begin ln = 1; o = p - 15; end
    e_vsync = (p <= 2);
    e_fs    = (p == 0);
    e_href  = (ln >= 0);
    e_ready = (p == 4) || (p == 14) || (ln >= 0 && (o % 2) == 1 && o != 7);
    e_under = uf && (p == 19);
    e_x = 10'd0;
    e_y = 9'd0;
    if (p == 14) e_y = 9'd1;
    if (ln >= 0) begin
      e_x = 10'((o + 1) / 2);
      e_y = 9'(ln);
    end
    e_byte = 8'h00;
    if (ln >= 0) begin
      px  = o / 2;
      lnv = 4'(ln);
      pxv = 4'(px);
      if (uf && ln == 1 && px == 2) e_byte = 8'h00;
      else if ((o % 2) == 0)        e_byte = {lnv, pxv};
      else                          e_byte = 8'hA5;
    end
  endtask

  // Run one frame from p=0, checking every cycle; stops (without stepping) after checking p==stop_at.
  task automatic run_frame(input bit uf, input int drop_at, input int stop_at);
    n_ready = 0;
    for (int p = 0; p < 27; p++) begin
      model(p, uf);
      chk($sformatf("vsync p%0d", p), 32'(vsync), 32'(e_vsync));
      chk($sformatf("href p%0d", p), 32'(href), 32'(e_href));
      chk($sformatf("fstart p%0d", p), 32'(fstart), 32'(e_fs));
      chk($sformatf("ready p%0d", p), 32'(ready), 32'(e_ready));
      chk($sformatf("underrun p%0d", p), 32'(underrun), 32'(e_under));
      if (vsync && href) chk($sformatf("vsync_href_overlap p%0d", p), 32'd1, 32'd0);
      if (e_href) chk($sformatf("byte p%0d", p), 32'(bout), 32'(e_byte));
      if (e_ready) begin
        chk($sformatf("frame_x p%0d", p), 32'(fx), 32'(e_x));
        chk($sformatf("frame_y p%0d", p), 32'(fy), 32'(e_y));
      end
      if (ready) n_ready++;
      if (p == stop_at) return;
      if (e_ready) begin
        pdata  = {e_y[3:0], e_x[3:0], 8'hA5};
        pvalid = !(uf && p == 18);
      end else begin
        pdata  = 16'hDEAD;
        pvalid = 1'b1;
      end
      if (p == drop_at) enable = 1'b0;
      step();
    end
    chk("ready_pulses_per_frame", 32'(n_ready), 32'd8);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    pdata  = 16'h0000;
    pvalid = 1'b1;
    step();
    step();
    chk("reset vsync", 32'(vsync), 32'd0);
    chk("reset href", 32'(href), 32'd0);
    chk("reset byte", 32'(bout), 32'd0);
    chk("reset fstart", 32'(fstart), 32'd0);
    chk("reset underrun", 32'(underrun), 32'd0);
    chk("reset ready", 32'(ready), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("idle no vsync", 32'(vsync), 32'd0);

    // Frame 1 plain, frame 2 with underrun and enable dropped during line 0
    enable = 1'b1;
    step();
    run_frame(1'b0, -1, -1);
    run_frame(1'b1, 7, -1);
    for (int i = 0; i < 4; i++) begin
      chk("idle after drop vsync", 32'(vsync), 32'd0);
      chk("idle after drop href", 32'(href), 32'd0);
      chk("idle after drop fstart", 32'(fstart), 32'd0);
      chk("idle after drop ready", 32'(ready), 32'd0);
      chk("idle after drop underrun", 32'(underrun), 32'd0);
      step();
    end

    // Frame 3 aborted by reset at line 0, x=2 high byte
    enable = 1'b1;
    step();
    run_frame(1'b0, -1, 9);
    chk("pre-reset byte x2", 32'(bout), 32'h02);
    rst = 1'b1;
    step();
    chk("abort href", 32'(href), 32'd0);
    chk("abort vsync", 32'(vsync), 32'd0);
    chk("abort byte", 32'(bout), 32'd0);
    chk("abort ready", 32'(ready), 32'd0);
    rst = 1'b0;
    step();
    run_frame(1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
